// File: rtl/cpu_stack_19bit_if.sv
// Control-unit-facing bus of the 19-bit CPU hardware stack.
// The control unit drives the request side and observes the stack status.
interface cpu_stack_19bit_if #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
);
    logic             PUSH;
    logic             POP;
    logic             CLR_ERR;
    logic [WIDTH-1:0] inpData;
    logic [WIDTH-1:0] opData;
    logic [CNT_W-1:0] COUNT;
    logic             FULL;
    logic             EMPTY;
    logic             OVF;
    logic             UNF;

    // Requests are zero-wait: anything presented at a falling edge is acted on
    // or, if illegal, dropped and flagged; there is no back-pressure.
    modport master (
        output PUSH, POP, CLR_ERR, inpData,
        input  opData, COUNT, FULL, EMPTY, OVF, UNF
    );

    modport slave (
        input  PUSH, POP, CLR_ERR, inpData,
        output opData, COUNT, FULL, EMPTY, OVF, UNF
    );
endinterface

// File: rtl/cpu_stack_19bit.sv
// LIFO for return addresses and saved operands; registered top-of-stack,
// sticky overflow/underflow flags, all state on the falling edge of CLK.
module cpu_stack_19bit #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input logic CLK,
    input logic RST_N,
    cpu_stack_19bit_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO_C   = CNT_W'(2);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] top_q;
    logic             ovf_q;
    logic             unf_q;

    logic full;
    logic empty;
    logic do_push;
    logic do_replace;
    logic do_pop;
    logic ovf_evt;
    logic unf_evt;
    logic [CNT_W-1:0] top_cnt;
    logic [CNT_W-1:0] below_cnt;
    logic [AW-1:0]    free_idx;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    below_idx;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);

    // PUSH+POP on an empty stack degenerates to a plain push (never full then).
    assign do_push    = bus.PUSH && !(bus.POP && !empty) && !full;
    assign do_replace = bus.PUSH && bus.POP && !empty;
    assign do_pop     = bus.POP && !bus.PUSH && !empty;
    assign ovf_evt    = bus.PUSH && !bus.POP && full;
    assign unf_evt    = bus.POP && !bus.PUSH && empty;

    assign top_cnt   = count_q - ONE_C;
    assign below_cnt = count_q - TWO_C;
    assign free_idx  = count_q[AW-1:0];
    assign top_idx   = top_cnt[AW-1:0];
    assign below_idx = below_cnt[AW-1:0];

    // Storage is never reset; entries above COUNT are unreachable anyway.
    always_ff @(negedge CLK) begin
        if (RST_N) begin
            if (do_push) begin
                mem[free_idx] <= bus.inpData;
            end else if (do_replace) begin
                mem[top_idx] <= bus.inpData;
            end
        end
    end

    always_ff @(negedge CLK) begin
        if (!RST_N) begin
            count_q <= '0;
            top_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            if (do_push) begin
                count_q <= count_q + ONE_C;
                top_q   <= bus.inpData;
            end else if (do_replace) begin
                top_q   <= bus.inpData;
            end else if (do_pop) begin
                count_q <= top_cnt;
                top_q   <= (count_q >= TWO_C) ? mem[below_idx] : '0;
            end
            // A fresh error event outranks a clear in the same cycle.
            if (ovf_evt) begin
                ovf_q <= 1'b1;
            end else if (bus.CLR_ERR) begin
                ovf_q <= 1'b0;
            end
            if (unf_evt) begin
                unf_q <= 1'b1;
            end else if (bus.CLR_ERR) begin
                unf_q <= 1'b0;
            end
        end
    end

    assign bus.opData = top_q;
    assign bus.COUNT  = count_q;
    assign bus.FULL   = full;
    assign bus.EMPTY  = empty;
    assign bus.OVF    = ovf_q;
    assign bus.UNF    = unf_q;
endmodule
